// File: rtl/arb_mux_rr_2to1_pkg.sv
// Shared types and constants for the two-input round-robin arbiter/mux.
// The grant-lock FSM states are only used when ARB_GRANT_LOCK_EN is defined.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/arb_mux_rr_2to1_if.sv
// Valid/ready bundle for two requesters and one registered output.
// slave is the arbiter side, master is the requester/consumer side.
interface arb_mux_rr_2to1_if #(
    parameter int NBITS = 8
) ();

    logic             in0_val;
    logic             in0_rdy;
    logic [NBITS-1:0] in0_data;
    logic             in0_last;

    logic             in1_val;
    logic             in1_rdy;
    logic [NBITS-1:0] in1_data;
    logic             in1_last;

    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_data;
    logic             out_sel;
    logic             out_last;

    modport slave (
        input  in0_val, in0_data, in0_last,
        input  in1_val, in1_data, in1_last,
        input  out_rdy,
        output in0_rdy, in1_rdy,
        output out_val, out_data, out_sel, out_last
    );

    modport master (
        output in0_val, in0_data, in0_last,
        output in1_val, in1_data, in1_last,
        output out_rdy,
        input  in0_rdy, in1_rdy,
        input  out_val, out_data, out_sel, out_last
    );

endinterface

// File: rtl/arb_mux_rr_2to1_rr_arb_2.sv
// Combinational two-way round-robin grant; force_en pins the grant to force_id
// while a multi-beat message owns the mux.
module rr_arb_2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       force_en,
    input  logic       force_id,
    output logic       gnt_val,
    output logic       gnt_id
);

    always_comb begin
        gnt_val = 1'b0;
        gnt_id  = SEL_IN0;
        if (force_en) begin
            gnt_val = req[force_id];
            gnt_id  = force_id;
        end else begin
            case (req)
                2'b01: begin
                    gnt_val = 1'b1;
                    gnt_id  = SEL_IN0;
                end
                2'b10: begin
                    gnt_val = 1'b1;
                    gnt_id  = SEL_IN1;
                end
                2'b11: begin
                    gnt_val = 1'b1;
                    gnt_id  = ~last_gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/arb_mux_rr_2to1.sv
// Round-robin 2:1 arbiter sharing one mux and one output register.
// Define ARB_GRANT_LOCK_EN to hold the grant until the winner's last beat.
module arb_mux_rr_2to1
    import arb_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    arb_mux_rr_2to1_if.slave  bus
);

    logic             outVal_q, outVal_d;
    logic [NBITS-1:0] outData_q, outData_d;
    logic             outSel_q, outSel_d;
    logic             lastGnt_q, lastGnt_d;

    logic             accept;
    logic             gntVal;
    logic             gntId;
    logic             forceEn;
    logic             forceId;
    logic             xfer;
    logic [NBITS-1:0] winData;

    rr_arb_2 u_arb (
        .req      ({bus.in1_val, bus.in0_val}),
        .last_gnt (lastGnt_q),
        .force_en (forceEn),
        .force_id (forceId),
        .gnt_val  (gntVal),
        .gnt_id   (gntId)
    );

    // rdy is held low during reset so nothing looks accepted while state is cleared
    assign accept      = !outVal_q || bus.out_rdy;
    assign bus.in0_rdy = reset_n && accept && gntVal && (gntId == SEL_IN0) && bus.in0_val;
    assign bus.in1_rdy = reset_n && accept && gntVal && (gntId == SEL_IN1) && bus.in1_val;
    assign xfer        = bus.in0_rdy || bus.in1_rdy;
    assign winData     = (gntId == SEL_IN1) ? bus.in1_data : bus.in0_data;

    always_comb begin
        outVal_d  = outVal_q;
        outData_d = outData_q;
        outSel_d  = outSel_q;
        lastGnt_d = lastGnt_q;
        if (xfer) begin
            outVal_d  = 1'b1;
            outData_d = winData;
            outSel_d  = gntId;
            lastGnt_d = gntId;
        end else if (accept) begin
            outVal_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outVal_q  <= 1'b0;
            outData_q <= '0;
            outSel_q  <= SEL_IN0;
            lastGnt_q <= SEL_IN1;
        end else begin
            outVal_q  <= outVal_d;
            outData_q <= outData_d;
            outSel_q  <= outSel_d;
            lastGnt_q <= lastGnt_d;
        end
    end

    assign bus.out_val  = outVal_q;
    assign bus.out_data = outData_q;
    assign bus.out_sel  = outSel_q;

`ifdef ARB_GRANT_LOCK_EN
    arb_state_t state_q, state_d;
    logic       winLast;
    logic       outLast_q;

    assign winLast = (gntId == SEL_IN1) ? bus.in1_last : bus.in0_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            outLast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                outLast_q <= winLast;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer && !winLast) begin
                    state_d = (gntId == SEL_IN1) ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (xfer && winLast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign forceEn      = (state_q != IDLE);
    assign forceId      = (state_q == LOCK1);
    assign bus.out_last = outLast_q;
`else
    logic unusedLast;

    assign unusedLast   = bus.in0_last ^ bus.in1_last;
    assign forceEn      = 1'b0;
    assign forceId      = SEL_IN0;
    assign bus.out_last = 1'b1;
`endif

endmodule

// File: tb/tb_arb_mux_rr_2to1.sv
// Directed bench for arb_mux_rr_2to1; expectations follow ARB_GRANT_LOCK_EN
// when the lock behaviour differs.
module tb_arb_mux_rr_2to1;

    localparam int NBITS = 8;

`ifdef ARB_GRANT_LOCK_EN
    localparam logic [31:0] RESET_LAST = 32'd0;
`else
    localparam logic [31:0] RESET_LAST = 32'd1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    arb_mux_rr_2to1_if #(.NBITS(NBITS)) bus ();

    arb_mux_rr_2to1 #(.NBITS(NBITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v0, input logic [NBITS-1:0] d0, input logic l0,
                                 input logic v1, input logic [NBITS-1:0] d1, input logic l1,
                                 input logic ordy);
        bus.in0_val  = v0;
        bus.in0_data = d0;
        bus.in0_last = l0;
        bus.in1_val  = v1;
        bus.in1_data = d1;
        bus.in1_last = l1;
        bus.out_rdy  = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] expData, input logic [31:0] expSel);
        checkOutput({tag, "_val"}, bus.out_val, 32'd1);
        checkOutput({tag, "_data"}, bus.out_data, expData);
        checkOutput({tag, "_sel"}, bus.out_sel, expSel);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;

        // Reset held with random inputs
        repeat (3) begin
            applyStimulus(1'($urandom), 8'($urandom), 1'($urandom),
                          1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            checkOutput("rst_rdy0", bus.in0_rdy, 32'd0);
            checkOutput("rst_rdy1", bus.in1_rdy, 32'd0);
            tick();
            checkOutput("rst_val", bus.out_val, 32'd0);
            checkOutput("rst_data", bus.out_data, 32'd0);
            checkOutput("rst_sel", bus.out_sel, 32'd0);
            checkOutput("rst_last", bus.out_last, RESET_LAST);
        end
        reset_n = 1'b1;

        // Contention: in0 wins first, then strict alternation
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1);
            checkOutput("cont_rdy0", bus.in0_rdy, 32'((i % 2) == 0));
            checkOutput("cont_rdy1", bus.in1_rdy, 32'((i % 2) == 1));
            tick();
            checkBeat("cont", ((i % 2) == 0) ? 32'h10 : 32'h20, 32'(i % 2));
        end

        // Single requester on input 1
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        checkOutput("single_rdy1", bus.in1_rdy, 32'd1);
        checkOutput("single_rdy0", bus.in0_rdy, 32'd0);
        tick();
        checkBeat("single", 32'hA5, 32'd1);

        // Backpressure with 8'h10 held in the output register
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkBeat("bp_load", 32'h10, 32'd0);
        repeat (3) begin
            applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
            checkOutput("bp_rdy0", bus.in0_rdy, 32'd0);
            checkOutput("bp_rdy1", bus.in1_rdy, 32'd0);
            tick();
            checkBeat("bp_hold", 32'h10, 32'd0);
        end
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1);
        checkOutput("bp_release_rdy1", bus.in1_rdy, 32'd1);
        tick();
        checkBeat("bp_drain_load", 32'h20, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("bp_empty", bus.out_val, 32'd0);

        // Three-beat message from in0 while in1 stays valid
`ifdef ARB_GRANT_LOCK_EN
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("lock_b1_rdy1", bus.in1_rdy, 32'd0);
        tick();
        checkBeat("lock_b1", 32'h01, 32'd0);
        checkOutput("lock_b1_last", bus.out_last, 32'd0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("lock_b2_rdy1", bus.in1_rdy, 32'd0);
        checkOutput("lock_b2_rdy0", bus.in0_rdy, 32'd1);
        tick();
        checkBeat("lock_b2", 32'h02, 32'd0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("lock_b3_rdy1", bus.in1_rdy, 32'd0);
        tick();
        checkBeat("lock_b3", 32'h03, 32'd0);
        checkOutput("lock_b3_last", bus.out_last, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("lock_after_rdy1", bus.in1_rdy, 32'd1);
        tick();
        checkBeat("lock_after", 32'h77, 32'd1);
`else
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("il_a_rdy0", bus.in0_rdy, 32'd1);
        tick();
        checkBeat("il_a", 32'h01, 32'd0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        checkOutput("il_b_rdy1", bus.in1_rdy, 32'd1);
        checkOutput("il_b_rdy0", bus.in0_rdy, 32'd0);
        tick();
        checkBeat("il_b", 32'h77, 32'd1);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        tick();
        checkBeat("il_c", 32'h02, 32'd0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        tick();
        checkBeat("il_d", 32'h77, 32'd1);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        tick();
        checkBeat("il_e", 32'h03, 32'd0);
        checkOutput("il_e_last", bus.out_last, 32'd1);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("lock_idle", bus.out_val, 32'd0);

        // Mid-operation reset while in0 holds the grant with a beat pending
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkBeat("mid_load", 32'h55, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
`ifdef ARB_GRANT_LOCK_EN
        checkOutput("mid_lock_rdy1", bus.in1_rdy, 32'd0);
`else
        checkOutput("mid_nolock_rdy1", bus.in1_rdy, 32'd1);
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0);
        checkOutput("mid_hold_val", bus.out_val, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_val", bus.out_val, 32'd0);
        checkOutput("mid_rst_data", bus.out_data, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
        checkOutput("post_rdy1", bus.in1_rdy, 32'd1);
        tick();
        checkBeat("post_in1", 32'h66, 32'd1);
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkBeat("post_in0", 32'h44, 32'd0);
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1);
        checkOutput("post_both_rdy1", bus.in1_rdy, 32'd1);
        checkOutput("post_both_rdy0", bus.in0_rdy, 32'd0);
        tick();
        checkBeat("post_both", 32'h20, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("final_idle", bus.out_val, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux_rr_2to1.md
# arb_mux_rr_2to1

Two-input round-robin arbiter that shares a single 2-to-1 data mux and one-entry output register between two valid/ready requesters. It sits in front of any shared downstream consumer and decides, cycle by cycle, which input the mux selects. It optionally holds a grant across multi-beat messages.

## Interface
- `NBITS`, default 8: data width of each input and of the output.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `in0_val` input 1: requester 0 has valid data.
- `in0_rdy` output 1: requester 0 data accepted this cycle.
- `in0_data` input NBITS: requester 0 payload.
- `in0_last` input 1: final beat of requester 0 message. Ignored unless `ARB_GRANT_LOCK_EN` is defined.
- `in1_val`, `in1_rdy`, `in1_data`, `in1_last`: same as the requester 0 ports, for requester 1.
- `out_val` output 1: output register holds valid data.
- `out_rdy` input 1: downstream accepts.
- `out_data` output NBITS: registered mux output.
- `out_sel` output 1: which input produced `out_data`.
- `out_last` output 1: registered copy of the winner's `last`. Constant 1 without the macro.

## Operation
- A transfer occurs on any port when `val && rdy` are both high at a rising edge.
- `accept = !out_val || out_rdy`. The output register loads on the same cycle it drains (pipelined ready).
- Grant is combinational from `in*_val`, the priority pointer `last_gnt`, and the lock state:
  - Only one input requests: that input wins.
  - Both inputs request: the input not equal to `last_gnt` wins.
- `inX_rdy = accept && grant==X && inX_val`. At most one `in*_rdy` is high in any cycle.
- On a transfer from input X:
  - `out_data <= inX_data`, `out_sel <= X`, `out_last <= inX_last`, `out_val <= 1`, `last_gnt <= X`.
- If `accept` is high and no input transfers, then `out_val <= 0`.
- `last_gnt` updates only on a transfer. Idle cycles do not rotate priority.
- Reset values: `out_val=0`, `out_data=0`, `out_sel=0`, `out_last=0`, `last_gnt=1` (input 0 wins the first contention), lock state `IDLE`.
- Reset asserted mid-operation clears all state immediately:
  - Any beat held in the output register is discarded.
  - Any lock is dropped.

## Timing
- Latency is 1 cycle from input transfer to `out_val` high.
- Throughput is 1 beat/cycle when `out_rdy` is held high.
- While `out_val && !out_rdy`:
  - `out_data`, `out_sel` and `out_last` hold stable.
  - Both `in*_rdy` are low.
- `in*_rdy` has a combinational path from `out_rdy` and `in*_val`. No path from `in*_data` to any `rdy`.

## Configuration
- Macro: `ARB_GRANT_LOCK_EN`.
- Defined: a 3-state FSM with states `IDLE`, `LOCK0`, `LOCK1`.
  - `IDLE` → `LOCKX` on a transfer from X with `inX_last=0`.
  - In `LOCKX`, grant is forced to X; the other input's `rdy` stays 0 even if X is not valid.
  - `LOCKX` → `IDLE` on a transfer from X with `inX_last=1`.
  - A single-beat message (`last=1`) never leaves `IDLE`.
- Undefined:
  - No FSM.
  - `in*_last` are ignored.
  - `out_last` is tied to 1.
  - Arbitration happens every beat.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t`.
  - Constants `SEL_IN0=1'b0` and `SEL_IN1=1'b1`.
- Sub-module `rr_arb_2`:
  - Combinational grant logic.
  - Inputs: `req[1:0]`, `last_gnt`, `force_en`, `force_id`.
  - Outputs: `gnt_val`, `gnt_id`.
- Top level holds the data mux, output register, `last_gnt`, and the FSM.

## Test plan
- Reset: hold `reset_n=0` with random inputs → all outputs 0, both `in*_rdy` 0. Release, then `in0_val=1`, `in1_val=1` → first `out_sel=0`.
- Single requester: `in1_val=1`, `in1_data=8'hA5`, `out_rdy=1` → `in1_rdy=1` that cycle; next cycle `out_val=1`, `out_data=8'hA5`, `out_sel=1`.
- Contention: both inputs valid for 6 cycles, `in0_data=8'h10`, `in1_data=8'h20`, `out_rdy=1` → `out_sel` sequence 0,1,0,1,0,1, one beat per cycle.
- Backpressure: `out_val=1` with `out_data=8'h10`, `out_rdy=0` for 3 cycles → output stable, `in*_rdy=0`. Raise `out_rdy` → drain and load in the same cycle.
- Lock (macro defined): in0 sends 3 beats 8'h01, 8'h02, 8'h03 with `last` on the third; in1 is continuously valid → output 01,02,03 then in1 data; `in1_rdy=0` throughout the in0 message. Without the macro → interleaved 01,in1,02,in1,03.
- Mid-operation reset: assert `reset_n=0` asynchronously during LOCK0 with `out_val=1` → `out_val` falls before the next edge. After release, state is `IDLE` and in1 is granted when both inputs request.
